cmp_share_arbiter: RTL and testbench

- Shares one 32-bit less-than comparator datapath among NREQ requesters, signed by default.
- Each requester presents an operand pair (a, b) under a valid/ready handshake. A round-robin arbiter selects one pair per cycle and feeds it into a 2-stage pipeline: operand register, then result register.
- The block returns lt = (a < b) tagged with the requester index, under a valid/ready handshake with full backpressure.
- It sits in front of the comparator in crypto/benchmark datapaths, where several units need occasional comparisons.

---
 rtl/cmp_share_arbiter_if.sv | 27 ++
 rtl/cmp_share_arbiter.sv | 114 +++++++++++
 tb/tb_cmp_share_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_share_arbiter_if.sv
// Requester and response handshake bundle for the shared less-than comparator.
// The arbiter takes the slave side; requesters and the result consumer take the master side.
interface cmp_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 32
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_lt;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_ready;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_lt, rsp_id
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_lt, rsp_id
  );
endinterface

// File: rtl/cmp_share_arbiter.sv
// Round-robin shared a<b comparator: operand stage then result stage, one result per cycle.
// Result valid one edge after accept; rsp_ready stall holds both stages and drops req_ready once S1 is full.
module cmp_share_arbiter #(
  parameter int NREQ   = 4,
  parameter int W      = 32,
  parameter int SIGNED = 1,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  cmp_share_arbiter_if.slave bus,
  output logic [CNTW-1:0]   cmp_count,
  output logic              busy
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic           s1_valid;
  logic [W-1:0]   s1_a;
  logic [W-1:0]   s1_b;
  logic [IDW-1:0] s1_id;
  logic           s2_valid;
  logic           s2_lt;
  logic [IDW-1:0] s2_id;
  logic [IDW-1:0] rr_ptr;

  logic           s2_load;
  logic           s1_free;
  logic           accept;
  logic           found;
  logic           cmp_lt;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] rr_next;
  logic [IDW:0]   cand;

  // First valid requester at or after rr_ptr, wrapping past NREQ-1.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!found && bus.req_valid[cand[IDW-1:0]]) begin
        found = 1'b1;
        grant = cand[IDW-1:0];
      end
    end
  end

  assign s2_load = s1_valid & (~s2_valid | bus.rsp_ready);
  assign s1_free = ~s1_valid | s2_load;
  assign accept  = s1_free & (|bus.req_valid) & ~rst;
  assign rr_next = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[grant] = 1'b1;
    end
  end

  // Signed form: a negative a against a non-negative b is always less; same signs compare magnitudes.
  always_comb begin
    if (SIGNED != 0) begin
      cmp_lt = (s1_a[W-1] & ~s1_b[W-1]) |
               (~(s1_a[W-1] ^ s1_b[W-1]) & (s1_a[W-2:0] < s1_b[W-2:0]));
    end else begin
      cmp_lt = s1_a < s1_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_id     <= '0;
      s2_valid  <= 1'b0;
      s2_lt     <= 1'b0;
      s2_id     <= '0;
      rr_ptr    <= '0;
      cmp_count <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_a     <= bus.req_a[grant*W +: W];
        s1_b     <= bus.req_b[grant*W +: W];
        s1_id    <= grant;
        rr_ptr   <= rr_next;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        s2_valid <= 1'b1;
        s2_lt    <= cmp_lt;
        s2_id    <= s1_id;
      end else if (bus.rsp_ready) begin
        s2_valid <= 1'b0;
      end

      if (s2_valid && bus.rsp_ready) begin
        cmp_count <= cmp_count + 1'b1;
      end
    end
  end

  assign bus.rsp_valid = s2_valid;
  assign bus.rsp_lt    = s2_lt;
  assign bus.rsp_id    = s2_id;
  assign busy          = s1_valid | s2_valid;
endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Bench for cmp_share_arbiter: queue-based reference model checked every cycle, plus directed literal cases.
module tb_cmp_share_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmp_share_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();
  logic [15:0] cmp_count;
  logic        busy;
  cmp_share_arbiter #(.NREQ(NREQ), .W(W), .SIGNED(1), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .cmp_count(cmp_count), .busy(busy)
  );

  cmp_share_arbiter_if #(.NREQ(2), .W(W)) bus2 ();
  logic [3:0] cnt2;
  logic       busy2;
  cmp_share_arbiter #(.NREQ(2), .W(W), .SIGNED(0), .CNTW(4)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .cmp_count(cnt2), .busy(busy2)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight requests in issue order, head is the one being offered downstream.
  typedef struct {
    logic lt;
    int   id;
    bit   in_s2;
  } ent_t;

  ent_t q[$];
  int   rr  = 0;
  int   cnt = 0;
  int   tot = 0;

  function automatic logic ref_lt(input logic [W-1:0] a, input logic [W-1:0] b);
    return $signed(a) < $signed(b);
  endfunction

  function automatic void eval(output logic [NREQ-1:0] er, output bit s2v, output bit s2l,
                               output bit acc, output int g);
    bit s1v;
    s2v = (q.size() > 0) && q[0].in_s2;
    s1v = (q.size() == 2) || ((q.size() == 1) && !q[0].in_s2);
    s2l = s1v && (!s2v || bus.rsp_ready);
    acc = (!s1v || s2l) && (bus.req_valid != '0) && !rst;
    g   = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (g < 0 && bus.req_valid[(rr + k) % NREQ]) g = (rr + k) % NREQ;
    end
    er = '0;
    if (acc) er[g] = 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [NREQ-1:0] er;
    bit s2v, s2l, acc;
    int g;
    if (rst) begin
      q.delete();
      rr  = 0;
      cnt = 0;
    end else begin
      eval(er, s2v, s2l, acc, g);
      if (s2v && bus.rsp_ready) begin
        void'(q.pop_front());
        cnt = (cnt + 1) % 65536;
        tot++;
      end
      if (s2l) foreach (q[i]) q[i].in_s2 = 1'b1;
      if (acc) begin
        q.push_back('{ref_lt(bus.req_a[g*W +: W], bus.req_b[g*W +: W]), g, 1'b0});
        rr = (g + 1) % NREQ;
      end
    end
  end

  logic [NREQ-1:0]   pv = '0;
  logic [NREQ-1:0]   pr = '0;
  logic [NREQ*W-1:0] pa = '0;
  logic [NREQ*W-1:0] pb = '0;

  always @(negedge clk) begin : compare
    logic [NREQ-1:0] er;
    bit s2v, s2l, acc;
    int g;
    if (rst) begin
      pv = '0;
    end else begin
      eval(er, s2v, s2l, acc, g);
      chk("req_ready", 64'(bus.req_ready), 64'(er));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(s2v));
      if (s2v) begin
        chk("rsp_lt", 64'(bus.rsp_lt), 64'(q[0].lt));
        chk("rsp_id", 64'(bus.rsp_id), 64'(q[0].id));
      end
      chk("busy", 64'(busy), 64'(q.size() != 0));
      chk("cmp_count", 64'(cmp_count), 64'(cnt));
      for (int i = 0; i < NREQ; i++) begin
        if (pv[i] && !pr[i]) begin
          chk("req_hold", 64'({bus.req_valid[i],
                              (bus.req_a[i*W +: W] == pa[i*W +: W]) &&
                              (bus.req_b[i*W +: W] == pb[i*W +: W])}), 64'(2'b11));
        end
      end
      pv = bus.req_valid;
      pr = bus.req_ready;
      pa = bus.req_a;
      pb = bus.req_b;
    end
  end

  int              rem[NREQ];
  int              p_start = 0;
  bit              rdm = 1'b0;
  logic [NREQ-1:0] rdy_s;

  task automatic load(input int i);
    logic [W-1:0] a, b;
    a = $urandom;
    case ($urandom_range(0, 3))
      0:       b = a;
      1:       b = a ^ 32'h8000_0000;
      default: b = $urandom;
    endcase
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_valid[i]    = 1'b1;
    rem[i]--;
  endtask

  task automatic set_pair(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_valid[i]    = 1'b1;
  endtask

  // One clock: sample grants mid-cycle, then act as the requesters just after the edge.
  task automatic step();
    @(negedge clk);
    rdy_s = bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i]) begin
        if (rdy_s[i]) begin
          if (rem[i] > 0) load(i);
          else bus.req_valid[i] = 1'b0;
        end
      end else if (rem[i] > 0 && $urandom_range(0, 99) < p_start) begin
        load(i);
      end
    end
    if (rdm) bus.rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected $finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "bench timeout");
  end

  initial begin
    int           gi;
    int           nacc;
    int           cyc;
    int           tot0;
    int           exp_g[6];
    logic [W-1:0] sa[4];
    logic [W-1:0] sb[4];
    logic         sl[4];
    logic [W-1:0] ua;
    logic [W-1:0] ub;

    exp_g = '{0, 1, 2, 3, 0, 1};
    sa    = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678};
    sb    = '{32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1234_5678};
    sl    = '{1'b1, 1'b0, 1'b1, 1'b0};
    foreach (rem[i]) rem[i] = 0;
    bus.req_valid  = 4'b1000;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.rsp_ready  = 1'b1;
    bus2.req_valid = '0;
    bus2.req_a     = '0;
    bus2.req_b     = '0;
    bus2.rsp_ready = 1'b1;

    // Reset state, with a requester already asking.
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_lt", 64'(bus.rsp_lt), 64'(0));
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_count", 64'(cmp_count), 64'(0));
    bus.req_valid = '0;
    @(posedge clk);
    #2 rst = 1'b0;

    // Signed corner cases on requester 0.
    for (int v = 0; v < 4; v++) begin
      set_pair(0, sa[v], sb[v]);
      step();
      chk("sgn_accept", 64'(rdy_s), 64'(4'b0001));
      step();
      chk("sgn_rsp", 64'({bus.rsp_valid, bus.rsp_lt, bus.rsp_id}), 64'({1'b1, sl[v], 2'b00}));
    end
    repeat (3) step();

    // Round-robin with everyone requesting from reset.
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 2;
      load(i);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      gi = -1;
      for (int i = 0; i < NREQ; i++) if (rdy_s[i]) gi = i;
      if (k < 6) chk("rr_grant", 64'(gi), 64'(exp_g[k]));
      if (k >= 1 && k <= 6)
        chk("rr_rsp_id", 64'({bus.rsp_valid, bus.rsp_id}), 64'({1'b1, 2'(exp_g[k-1])}));
      if (k == 7) chk("rr_count", 64'(cmp_count), 64'(6));
    end
    repeat (6) step();

    // Backpressure: stall the consumer with four requesters pending.
    rst           = 1'b1;
    bus.rsp_ready = 1'b0;
    rem[0] = 2;
    rem[1] = 1;
    rem[2] = 1;
    rem[3] = 1;
    for (int i = 0; i < NREQ; i++) load(i);
    @(posedge clk);
    #2 rst = 1'b0;
    nacc = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      nacc += $countones(rdy_s);
      if (k == 2) chk("bp_rsp_mid", 64'({bus.rsp_valid, bus.rsp_id}), 64'({1'b1, 2'd0}));
    end
    chk("bp_accepts", 64'(nacc), 64'(2));
    chk("bp_ready_low", 64'(rdy_s), 64'(0));
    chk("bp_rsp_end", 64'({bus.rsp_valid, bus.rsp_id}), 64'({1'b1, 2'd0}));
    bus.rsp_ready = 1'b1;
    repeat (8) step();
    chk("bp_count", 64'(cmp_count), 64'(5));

    // Asynchronous reset with both stages full; rr_ptr would otherwise point at 3.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 1;
      load(i);
    end
    repeat (3) step();
    chk("pre_rst_full", 64'({bus.rsp_valid, busy}), 64'(2'b11));
    #2 rst = 1'b1;
    #1;
    chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_count", 64'(cmp_count), 64'(0));
    chk("arst_req_ready", 64'(bus.req_ready), 64'(0));
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    step();
    chk("rst_first_grant", 64'(rdy_s), 64'(4'b0001));
    repeat (6) step();

    // Random soak of 10000 requests with random consumer stalls.
    tot0    = tot;
    p_start = 70;
    rdm     = 1'b1;
    foreach (rem[i]) rem[i] = 2500;
    cyc = 0;
    while (cyc < 40000 && (rem.sum() != 0 || bus.req_valid != '0 || busy)) begin
      step();
      cyc++;
    end
    rdm           = 1'b0;
    bus.rsp_ready = 1'b1;
    chk("soak_done", 64'(cyc < 40000), 64'(1));
    chk("soak_total", 64'(tot - tot0), 64'(10000));
    chk("soak_drained", 64'(q.size()), 64'(0));

    // Unsigned build with a 4-bit counter: 17 back-to-back results.
    for (int k = 0; k < 17; k++) begin
      case (k)
        0:       begin ua = 32'hFFFF_FFFF; ub = 32'h0000_0000; end
        1:       begin ua = 32'h0000_0001; ub = 32'h8000_0000; end
        default: begin ua = 32'(k);        ub = 32'(k);        end
      endcase
      bus2.req_a[W-1:0] = ua;
      bus2.req_b[W-1:0] = ub;
      bus2.req_valid    = 2'b01;
      @(posedge clk);
      #1;
      if (k == 1) chk("uns_ffff_vs_0", 64'({bus2.rsp_valid, bus2.rsp_lt}), 64'(2'b10));
      if (k == 2) chk("uns_1_vs_8000", 64'({bus2.rsp_valid, bus2.rsp_lt}), 64'(2'b11));
    end
    bus2.req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("cnt_wrap", 64'(cnt2), 64'(1));
    chk("uns_idle", 64'(busy2), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
